// File: rtl/hw_bench_ts_collector.sv
// Pairs command and status timestamps in order and emits their latency on an AXI4-Stream result port.
// Optional statistics (count/min/max/sum plus clear) are built only when HW_BENCH_TS_STATS_EN is defined.
module hw_bench_ts_collector #(
  parameter int C_TS_WIDTH   = 64,
  parameter int C_DEPTH_LOG2 = 5
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      cmdTs_tvalid,
  output logic                      cmdTs_tready,
  input  logic [C_TS_WIDTH-1:0]     cmdTs_tdata,
  input  logic                      cmdTs_tlast,
  input  logic                      stsTs_tvalid,
  output logic                      stsTs_tready,
  input  logic [C_TS_WIDTH-1:0]     stsTs_tdata,
  input  logic                      stsTs_tlast,
  output logic                      res_tvalid,
  input  logic                      res_tready,
  output logic [C_TS_WIDTH-1:0]     res_tdata,
  output logic [C_TS_WIDTH/8-1:0]   res_tkeep,
  output logic                      res_tlast,
  input  logic                      clear,
  output logic [C_DEPTH_LOG2:0]     outstanding,
  output logic [31:0]               stat_count,
  output logic [C_TS_WIDTH-1:0]     stat_min,
  output logic [C_TS_WIDTH-1:0]     stat_max,
  output logic [C_TS_WIDTH-1:0]     stat_sum
);

  localparam int unsigned DEPTH = 1 << C_DEPTH_LOG2;
  localparam logic [C_DEPTH_LOG2-1:0] PTR_ONE = {{(C_DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [C_DEPTH_LOG2:0]   CNT_ONE = {{C_DEPTH_LOG2{1'b0}}, 1'b1};

  logic [C_TS_WIDTH-1:0]   pending_mem [DEPTH];
  logic [C_DEPTH_LOG2-1:0] wr_ptr;
  logic [C_DEPTH_LOG2-1:0] rd_ptr;
  logic [C_DEPTH_LOG2:0]   count_next;
  logic                    cmd_ready_q;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [C_TS_WIDTH-1:0]   latency;

  assign empty        = (outstanding == '0);
  assign cmdTs_tready = cmd_ready_q;
  assign stsTs_tready = !empty && (!res_tvalid || res_tready);
  assign push         = cmdTs_tvalid && cmdTs_tready;
  assign pop          = stsTs_tvalid && stsTs_tready;
  assign latency      = stsTs_tdata - pending_mem[rd_ptr];
  assign res_tkeep    = '1;
  assign res_tlast    = 1'b1;

  always_comb begin
    count_next = outstanding;
    if (push && !pop)
      count_next = outstanding + CNT_ONE;
    else if (pop && !push)
      count_next = outstanding - CNT_ONE;
  end

  always_ff @(posedge ap_clk) begin
    if (push)
      pending_mem[wr_ptr] <= cmdTs_tdata;
  end

  // Ready is registered from the next occupancy, so a pop while full frees a slot one cycle later.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      outstanding <= count_next;
      cmd_ready_q <= !count_next[C_DEPTH_LOG2];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      res_tvalid <= 1'b0;
      res_tdata  <= '0;
    end else if (pop) begin
      res_tvalid <= 1'b1;
      res_tdata  <= latency;
    end else if (res_tready) begin
      res_tvalid <= 1'b0;
    end
  end

`ifdef HW_BENCH_TS_STATS_EN
  logic [31:0]           cnt_base;
  logic [C_TS_WIDTH-1:0] min_base;
  logic [C_TS_WIDTH-1:0] max_base;
  logic [C_TS_WIDTH-1:0] sum_base;
  logic                  unused_tlast;

  assign unused_tlast = cmdTs_tlast ^ stsTs_tlast;

  // A clear coinciding with a pop folds the new sample into freshly cleared statistics.
  always_comb begin
    cnt_base = clear ? '0 : stat_count;
    min_base = clear ? '1 : stat_min;
    max_base = clear ? '0 : stat_max;
    sum_base = clear ? '0 : stat_sum;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      stat_count <= '0;
      stat_min   <= '1;
      stat_max   <= '0;
      stat_sum   <= '0;
    end else if (pop) begin
      stat_count <= (cnt_base == 32'hFFFF_FFFF) ? cnt_base : cnt_base + 32'd1;
      stat_min   <= (latency < min_base) ? latency : min_base;
      stat_max   <= (latency > max_base) ? latency : max_base;
      stat_sum   <= sum_base + latency;
    end else if (clear) begin
      stat_count <= '0;
      stat_min   <= '1;
      stat_max   <= '0;
      stat_sum   <= '0;
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = cmdTs_tlast ^ stsTs_tlast ^ clear;
  assign stat_count    = '0;
  assign stat_min      = '0;
  assign stat_max      = '0;
  assign stat_sum      = '0;
`endif

endmodule

// File: tb/tb_hw_bench_ts_collector.sv
// Scoreboard bench for hw_bench_ts_collector: a command-FIFO model predicts each latency when the status beat is accepted.
// Statistics expectations follow HW_BENCH_TS_STATS_EN (zeros when it is undefined).
module tb_hw_bench_ts_collector;

  localparam int TSW = 64;
  localparam int DLG = 5;
`ifdef HW_BENCH_TS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           ap_clk = 1'b0;
  logic           ap_rst_n;
  logic           cmdTs_tvalid, cmdTs_tready, cmdTs_tlast;
  logic [TSW-1:0] cmdTs_tdata;
  logic           stsTs_tvalid, stsTs_tready, stsTs_tlast;
  logic [TSW-1:0] stsTs_tdata;
  logic           res_tvalid, res_tready, res_tlast;
  logic [TSW-1:0] res_tdata;
  logic [TSW/8-1:0] res_tkeep;
  logic           clear;
  logic [DLG:0]   outstanding;
  logic [31:0]    stat_count;
  logic [TSW-1:0] stat_min, stat_max, stat_sum;

  hw_bench_ts_collector #(.C_TS_WIDTH(TSW), .C_DEPTH_LOG2(DLG)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmdTs_tvalid(cmdTs_tvalid), .cmdTs_tready(cmdTs_tready),
    .cmdTs_tdata(cmdTs_tdata), .cmdTs_tlast(cmdTs_tlast),
    .stsTs_tvalid(stsTs_tvalid), .stsTs_tready(stsTs_tready),
    .stsTs_tdata(stsTs_tdata), .stsTs_tlast(stsTs_tlast),
    .res_tvalid(res_tvalid), .res_tready(res_tready), .res_tdata(res_tdata),
    .res_tkeep(res_tkeep), .res_tlast(res_tlast), .clear(clear),
    .outstanding(outstanding), .stat_count(stat_count),
    .stat_min(stat_min), .stat_max(stat_max), .stat_sum(stat_sum)
  );

  always #5 ap_clk = ~ap_clk;

  int             checks = 0;
  int             errors = 0;
  logic [TSW-1:0] cmdModel [$];
  logic [TSW-1:0] expQ [$];
  logic [31:0]    mCount;
  logic [TSW-1:0] mMin, mMax, mSum;
  bit             lastCmdHs, lastStsHs;

  task automatic checkOutput(input string tag, input logic [TSW-1:0] observed, input logic [TSW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetStatsModel();
    mCount = '0;
    mMin   = '1;
    mMax   = '0;
    mSum   = '0;
  endtask

  // Samples handshakes 1ns after inputs are driven, updates the models, then advances one clock.
  task automatic applyStimulus();
    logic [TSW-1:0] lat;
    #1;
    lastCmdHs = cmdTs_tvalid && cmdTs_tready;
    lastStsHs = stsTs_tvalid && stsTs_tready;
    if (clear) resetStatsModel();
    if (lastCmdHs) cmdModel.push_back(cmdTs_tdata);
    if (lastStsHs) begin
      if (cmdModel.size() == 0) begin
        checkOutput("sts_accepted_while_empty", 1, 0);
      end else begin
        lat = stsTs_tdata - cmdModel.pop_front();
        expQ.push_back(lat);
        if (mCount != 32'hFFFF_FFFF) mCount = mCount + 1;
        if (lat < mMin) mMin = lat;
        if (lat > mMax) mMax = lat;
        mSum = mSum + lat;
      end
    end
    if (res_tvalid && res_tready) begin
      if (expQ.size() == 0) checkOutput("unexpected_result", 1, 0);
      else checkOutput("res_tdata", res_tdata, expQ.pop_front());
      checkOutput("res_tkeep", TSW'(res_tkeep), TSW'(8'hFF));
      checkOutput("res_tlast", TSW'(res_tlast), 1);
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic checkStats(input string tag);
    checkOutput({tag, "_count"}, TSW'(stat_count), STATS ? TSW'(mCount) : '0);
    checkOutput({tag, "_min"}, stat_min, STATS ? mMin : '0);
    checkOutput({tag, "_max"}, stat_max, STATS ? mMax : '0);
    checkOutput({tag, "_sum"}, stat_sum, STATS ? mSum : '0);
  endtask

  task automatic sendCmd(input logic [TSW-1:0] ts);
    int n = 0;
    cmdTs_tvalid = 1'b1;
    cmdTs_tdata  = ts;
    do begin
      applyStimulus();
      n++;
    end while (!lastCmdHs && n < 64);
    cmdTs_tvalid = 1'b0;
    if (!lastCmdHs) checkOutput("cmd_timeout", 0, 1);
  endtask

  task automatic sendSts(input logic [TSW-1:0] ts);
    int n = 0;
    stsTs_tvalid = 1'b1;
    stsTs_tdata  = ts;
    do begin
      applyStimulus();
      n++;
    end while (!lastStsHs && n < 64);
    stsTs_tvalid = 1'b0;
    if (!lastStsHs) checkOutput("sts_timeout", 0, 1);
  endtask

  task automatic applyReset(input string tag);
    ap_rst_n     = 1'b0;
    cmdTs_tvalid = 1'b0;
    stsTs_tvalid = 1'b0;
    clear        = 1'b0;
    @(posedge ap_clk);
    #1;
    cmdModel.delete();
    expQ.delete();
    resetStatsModel();
    checkOutput({tag, "_cmd_ready_in_reset"}, TSW'(cmdTs_tready), 0);
    checkOutput({tag, "_sts_ready"}, TSW'(stsTs_tready), 0);
    checkOutput({tag, "_res_tvalid"}, TSW'(res_tvalid), 0);
    checkOutput({tag, "_res_tdata"}, res_tdata, 0);
    checkOutput({tag, "_outstanding"}, TSW'(outstanding), 0);
    checkStats(tag);
    ap_rst_n = 1'b1;
    applyStimulus();
    checkOutput({tag, "_cmd_ready_after"}, TSW'(cmdTs_tready), 1);
  endtask

  initial begin
    int hsCnt;
    ap_rst_n = 1'b0;
    cmdTs_tvalid = 1'b0; cmdTs_tdata = '0; cmdTs_tlast = 1'b1;
    stsTs_tvalid = 1'b0; stsTs_tdata = '0; stsTs_tlast = 1'b1;
    res_tready = 1'b1; clear = 1'b0;
    resetStatsModel();
    applyReset("reset");

    // Single pair
    sendCmd(100);
    sendSts(250);
    checkOutput("pair_valid", TSW'(res_tvalid), 1);
    checkOutput("pair_data", res_tdata, 150);
    checkOutput("pair_keep", TSW'(res_tkeep), TSW'(8'hFF));
    checkOutput("pair_last", TSW'(res_tlast), 1);
    checkOutput("pair_count", TSW'(stat_count), STATS ? 1 : 0);
    checkOutput("pair_min", stat_min, STATS ? 150 : 0);
    checkOutput("pair_max", stat_max, STATS ? 150 : 0);
    checkOutput("pair_sum", stat_sum, STATS ? 150 : 0);
    applyStimulus();

    // Wrap-around
    sendCmd(64'hFFFF_FFFF_FFFF_FFF0);
    sendSts(64'h10);
    checkOutput("wrap_data", res_tdata, 64'h20);
    applyStimulus();

    // Fill the pending FIFO
    for (int i = 0; i < 32; i++) sendCmd(64'(i * 3));
    checkOutput("fill_outstanding", TSW'(outstanding), 32);
    checkOutput("fill_cmd_ready", TSW'(cmdTs_tready), 0);
    sendSts(1000);
    checkOutput("fill_pop_cmd_ready", TSW'(cmdTs_tready), 1);
    checkOutput("fill_pop_outstanding", TSW'(outstanding), 31);
    hsCnt = 0;
    stsTs_tvalid = 1'b1;
    for (int i = 0; i < 31; i++) begin
      stsTs_tdata = 64'(2000 + i * 7);
      applyStimulus();
      if (lastStsHs) hsCnt++;
    end
    stsTs_tvalid = 1'b0;
    checkOutput("drain_rate", TSW'(hsCnt), 31);
    applyStimulus();
    checkOutput("drain_outstanding", TSW'(outstanding), 0);

    // Backpressure
    sendCmd(10);
    sendCmd(20);
    res_tready = 1'b0;
    sendSts(15);
    checkOutput("bp_first", res_tdata, 5);
    stsTs_tvalid = 1'b1;
    stsTs_tdata  = 40;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkOutput("bp_hold_data", res_tdata, 5);
      checkOutput("bp_sts_ready", TSW'(stsTs_tready), 0);
    end
    res_tready = 1'b1;
    applyStimulus();
    stsTs_tvalid = 1'b0;
    checkOutput("bp_release_hs", TSW'(lastStsHs), 1);
    checkOutput("bp_second", res_tdata, 20);
    applyStimulus();

    // Status arrives before its command
    stsTs_tvalid = 1'b1;
    stsTs_tdata  = 50;
    applyStimulus();
    checkOutput("early_sts_ready", TSW'(stsTs_tready), 0);
    cmdTs_tvalid = 1'b1;
    cmdTs_tdata  = 7;
    applyStimulus();
    cmdTs_tvalid = 1'b0;
    checkOutput("early_no_bypass", TSW'(lastStsHs), 0);
    applyStimulus();
    stsTs_tvalid = 1'b0;
    checkOutput("early_accept_next", TSW'(lastStsHs), 1);
    checkOutput("early_data", res_tdata, 43);
    applyStimulus();
    checkStats("accum");

    // Clear coinciding with a pop, then clear alone
    sendCmd(1);
    clear = 1'b1;
    sendSts(10);
    clear = 1'b0;
    checkOutput("clr_pop_count", TSW'(stat_count), STATS ? 1 : 0);
    checkOutput("clr_pop_min", stat_min, STATS ? 9 : 0);
    checkOutput("clr_pop_max", stat_max, STATS ? 9 : 0);
    checkOutput("clr_pop_sum", stat_sum, STATS ? 9 : 0);
    applyStimulus();
    clear = 1'b1;
    applyStimulus();
    clear = 1'b0;
    checkStats("clr_only");

    // Reset with work in flight
    res_tready = 1'b0;
    for (int i = 0; i < 4; i++) sendCmd(64'(100 + i));
    sendSts(200);
    checkOutput("pre_rst_outstanding", TSW'(outstanding), 3);
    checkOutput("pre_rst_valid", TSW'(res_tvalid), 1);
    applyReset("midrst");
    res_tready = 1'b1;
    sendCmd(5);
    sendSts(8);
    checkOutput("post_rst_data", res_tdata, 3);
    applyStimulus();
    checkStats("post_rst");

    checkOutput("scoreboard_empty", TSW'(expQ.size()), 0);
    checkOutput("final_outstanding", TSW'(outstanding), TSW'(cmdModel.size()));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hw_bench_ts_collector.md
# hw_bench_ts_collector

Timestamp collector for the hardware benchmark plugin. It consumes the command-timestamp and status-timestamp streams emitted by the benchmark tap role and pairs them in order: one command timestamp with one status timestamp. For each pair it emits the 64-bit latency (status minus command) on an AXI4-Stream result interface and keeps running statistics. It sits between the tap role and the host-facing result FIFO/DMA.

## Interface
- C_TS_WIDTH, 64: timestamp and latency width.
- C_DEPTH_LOG2, 5: log2 of pending-command FIFO depth (32 outstanding commands).
- ap_clk  in  1  sole clock, all logic rising-edge.
- ap_rst_n  in  1  reset; **one clock; reset is synchronous and active-low**.
- cmdTs_tvalid / cmdTs_tready  in / out  1  command-timestamp handshake.
- cmdTs_tdata  in  C_TS_WIDTH  command issue timestamp.
- cmdTs_tlast  in  1  ignored; every beat is a complete timestamp.
- stsTs_tvalid / stsTs_tready  in / out  1  status-timestamp handshake.
- stsTs_tdata  in  C_TS_WIDTH  status return timestamp.
- stsTs_tlast  in  1  ignored.
- res_tvalid / res_tready  out / in  1  result handshake.
- res_tdata  out  C_TS_WIDTH  latency in cycles.
- res_tkeep  out  C_TS_WIDTH/8  constant all-ones.
- res_tlast  out  1  constant 1.
- clear  in  1  single-cycle pulse; clears statistics only.
- outstanding  out  C_DEPTH_LOG2+1  number of pending command timestamps.
- stat_count  out  32  number of results produced, saturating.
- stat_min / stat_max / stat_sum  out  C_TS_WIDTH  latency minimum / maximum / wrapping sum.

## Operation
- The pending FIFO holds 2^C_DEPTH_LOG2 command timestamps.
- cmdTs_tready = !full. A push happens on the cmdTs handshake.
- Output register: res_tvalid plus res_tdata.
- stsTs_tready = !empty && (!res_tvalid || res_tready).
- On an stsTs handshake:
  - pop the FIFO head;
  - load res_tdata = stsTs_tdata − head, modulo 2^C_TS_WIDTH;
  - set res_tvalid.
- res_tvalid clears on a res handshake with no simultaneous load.
- Pairing is strictly in order. There is no error detection.
- When the FIFO is empty, a status timestamp waits with tready low. There is no bypass from cmdTs to stsTs.
- outstanding changes as follows:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on a simultaneous push and pop.
- When full, a pop in cycle N lets cmdTs_tready rise in cycle N+1; there is no same-cycle push-through.
- Statistics update on every pop:
  - stat_count += 1, saturating at 0xFFFF_FFFF;
  - stat_min = min(stat_min, latency);
  - stat_max = max(stat_max, latency);
  - stat_sum += latency, wrapping.
- clear resets the statistics to their reset values. FIFO, outstanding and the result register are untouched.
- If clear and a pop occur in the same cycle, the statistics are cleared and then take the new sample:
  - count = 1;
  - min = max = sum = latency.

## Timing
- Reset values:
  - cmdTs_tready 0 while in reset, 1 in the first cycle after;
  - stsTs_tready 0, res_tvalid 0, res_tdata 0, outstanding 0;
  - stat_count 0, stat_min all-ones, stat_max 0, stat_sum 0.
- Reset mid-operation flushes the FIFO and drops any held result.
- A push in cycle N makes the FIFO non-empty in cycle N+1.
- Result latency: an stsTs handshake in cycle N gives res_tvalid high in cycle N+1 with res_tdata valid.
- Statistics reflect the sample in cycle N+1.
- Under res_tready low, res_tdata is stable and stsTs_tready is 0.
- Sustained throughput is one result per cycle when res_tready is held high.

## Configuration
- HW_BENCH_TS_STATS_EN
  - Defined: the statistics registers and clear logic are built as described.
  - Undefined: no statistics logic. stat_count, stat_min, stat_max and stat_sum are driven constant 0, and clear is ignored. Stream behaviour is identical.

## Test plan
- Single pair: cmd 100, then sts 250 -> res_tdata 150, tlast 1, tkeep 0xFF; count 1, min = max = sum = 150.
- Wrap-around: cmd 0xFFFF_FFFF_FFFF_FFF0, sts 0x10 -> res_tdata 0x20.
- Fill: 32 cmd beats with no sts -> outstanding 32, cmdTs_tready 0. One sts pop -> tready 1 the next cycle, outstanding 31.
- Backpressure: cmds 10, 20; sts 15, 40; res_tready held 0 -> res_tdata 5 held, stsTs_tready 0. Release -> results 5 then 20, in order.
- Status before command: stsTs_tvalid with the FIFO empty -> stsTs_tready 0. cmd 7 pushed in cycle N -> sts accepted in cycle N+1.
- Clear and reset: clear coincident with a pop of latency 9 -> count 1, min = max = sum = 9. ap_rst_n low for 1 cycle with 3 outstanding -> outstanding 0, res_tvalid 0.
